fsm_rr_arbiter: RTL and testbench
=================================

// Module: fsm_rr_arbiter
// PURPOSE
//   Round-robin arbiter, written as an explicit FSM, that shares one
//   single-input sequence-detector FSM (single serial input a, outputs x/y)
//   among N requesters.
//   Grants one requester at a time, bounds how long it may hold the resource,
//   and forces a one-cycle idle gap between owners so the shared FSM sees a
//   clean hand-over.
// PARAMETERS
//   N         4  number of requesters; legal range 2..8
//   MAX_HOLD  8  max consecutive grant cycles per owner; legal range 1..255
// PORTS
//   clk      in   1           system clock; all state updates on rising edge
//   reset    in   1           asynchronous, active-high reset
//   req      in   N           per-requester request level, held while wanting access
//   gnt      out  N           one-hot grant, registered; all-zero when idle
//   owner    out  clog2(N)    index of current grantee; 0 when idle
//   busy     out  1           1 while in GRANT state (== |gnt)
//   expired  out  1           1-cycle pulse: grant removed by MAX_HOLD, not by req drop
// BEHAVIOUR
//   Reset: reset=1 forces outputs immediately, with no clock needed:
//     state=IDLE, gnt=0, owner=0, busy=0, expired=0, ptr=0, hold_cnt=0.
//     Applies mid-grant too: the grant is lost, with no expired pulse.
//   State IDLE (arbitrate):
//     If req!=0, pick the first set bit scanning ptr, ptr+1, .. N-1, 0, .. (wrap).
//     Next edge: state=GRANT, gnt=onehot(pick), owner=pick, hold_cnt=1.
//     If req==0, stay in IDLE.
//     Latency req->gnt is exactly 1 clock.
//   State GRANT:
//     Release: req[owner]==0 at the edge. Next edge: state=IDLE, gnt=0,
//       ptr=(owner+1) mod N, expired=0.
//     Expiry: req[owner]==1 and hold_cnt==MAX_HOLD. Next edge: state=IDLE,
//       gnt=0, ptr=(owner+1) mod N, expired=1 for one cycle.
//     Otherwise: hold_cnt++, gnt unchanged.
//       Other req bits are ignored while in GRANT.
//     Release takes precedence if it coincides with hold_cnt==MAX_HOLD
//       (no expired pulse).
//   Hand-over gap: after every GRANT->IDLE transition, gnt=0 for at least one
//     full cycle before any new grant.
//   Fairness: ptr advances past the last owner, so with all req=1 the grants
//     rotate 0,1,2,..N-1,0 and any requester waits at most (N-1)*(MAX_HOLD+1)
//     cycles.
//   Widths:
//     hold_cnt is 8 bits and saturates at MAX_HOLD, so it never wraps.
//     ptr/owner wrap modulo N; N not a power of two must not reach an
//       illegal index.
//   Glitch-free: gnt, owner, busy and expired are all driven from flops;
//     only the next-state logic is combinational.
//   X on req in IDLE is a bench error. The RTL gives no guarantee for it.
// STRUCTURE
//   Shared defs header (fsm_arb_defs.vh): state encodings ST_IDLE=1'b0,
//     ST_GRANT=1'b1; CNT_W=8.
//   Sub-module rr_pick: combinational rotating-priority encoder
//     (inputs req, ptr; outputs pick, any).
//     Instantiated once. The top holds the FSM, ptr, hold_cnt and output regs.
//   Two-process FSM: a state register with async reset, plus a combinational
//     next-state/next-output block.
// TESTING (N=4, MAX_HOLD=4, 10 ns clock, reset released at 10 ns)
//   1. Reset/idle: req=0 for 5 cycles -> gnt=0000, owner=0, busy=0 throughout.
//   2. Single request: req=0100 held 2 cycles then 0 -> gnt=0100 from edge+1
//      for 2 cycles, then 0000; next grant with req=1111 goes to index 3
//      (ptr=3).
//   3. Expiry: req=0001 held 10 cycles -> gnt=0001 for 4 cycles, expired=1
//      on the first gap cycle, 1 gap cycle, then regrant 0001 (sole requester).
//   4. Rotation: req=1111 constant -> owners 0,1,2,3,0, each 4 cycles, with
//      1 idle cycle between; expired pulses 4 times per rotation.
//   5. Release at MAX_HOLD: req[owner] drops on the same edge where
//      hold_cnt==4 -> IDLE with expired=0.
//   6. Async reset mid-grant: assert reset at 3 ns after an edge during
//      gnt=0010 -> gnt=0000 within the same cycle (before the next edge);
//      after release with req=1111, the grant goes to index 0.

Source files
------------

// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding,
// hold-counter width and a modulo-increment helper for the rotating pointer.
package fsm_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request bit scanning ptr, ptr+1, ..
// with wrap-around. Purely combinational.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] pick,
  output logic         any
);

  logic [W-1:0] idx;

  // Scan from the far end back towards ptr so the last hit is the closest one.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter FSM sharing one downstream sequence detector among N
// requesters, with a hold limit per owner and a one-cycle hand-over gap.
module fsm_rr_arbiter
  import fsm_rr_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 expired
);

  localparam int W = $clog2(N);

  arb_state_e       state, state_nxt;
  logic [W-1:0]     ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [W-1:0]     owner_nxt;
  logic             busy_nxt;
  logic             expired_nxt;
  logic [W-1:0]     pick;
  logic             any;

  rr_pick #(.N(N), .W(W)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
      expired  <= expired_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    owner_nxt    = owner;
    busy_nxt     = busy;
    expired_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_nxt   = '0;
        owner_nxt = '0;
        busy_nxt  = 1'b0;
        if (any) begin
          state_nxt     = ST_GRANT;
          gnt_nxt[pick] = 1'b1;
          owner_nxt     = pick;
          busy_nxt      = 1'b1;
          hold_cnt_nxt  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // Release wins over expiry when both happen on the same edge.
        if (!req[owner] || (hold_cnt >= CNT_W'(MAX_HOLD))) begin
          state_nxt    = ST_IDLE;
          gnt_nxt      = '0;
          owner_nxt    = '0;
          busy_nxt     = 1'b0;
          hold_cnt_nxt = '0;
          ptr_nxt      = W'(wrap_inc(int'(owner), N));
          expired_nxt  = req[owner];
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        owner_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter (N=4, MAX_HOLD=4) with an integer-level
// reference model checked every cycle plus hand-computed spot checks.
module tb_fsm_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         expired;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: -1 means nobody owns the resource.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_exp   = 0;

  fsm_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .expired (expired)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_exp   = 0;
    end else if (m_owner < 0) begin
      m_exp = 0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_held  = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_exp   = 0;
    end else if (m_held == MAX_HOLD) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_exp   = 1;
    end else begin
      m_held = m_held + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_gnt",     int'(gnt),     (m_owner < 0) ? 0 : (1 << m_owner));
      chk("model_owner",   int'(owner),   (m_owner < 0) ? 0 : m_owner);
      chk("model_busy",    int'(busy),    (m_owner < 0) ? 0 : 1);
      chk("model_expired", int'(expired), m_exp);
    end
  end

  initial begin
    int exp_cnt;
    #10 reset = 1'b0;

    // Reset / idle
    chk("reset_gnt", int'(gnt), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_gnt",   int'(gnt),   0);
      chk("idle_owner", int'(owner), 0);
      chk("idle_busy",  int'(busy),  0);
    end

    // Single request, then ptr lands past the released owner
    req = 4'b0100;
    step();
    chk("single_gnt1", int'(gnt), 4);
    chk("single_own1", int'(owner), 2);
    step();
    chk("single_gnt2", int'(gnt), 4);
    req = 4'b0000;
    step();
    chk("single_rel_gnt", int'(gnt), 0);
    chk("single_rel_exp", int'(expired), 0);
    req = 4'b1111;
    step();
    chk("ptr3_gnt",   int'(gnt), 8);
    chk("ptr3_owner", int'(owner), 3);
    req = 4'b0000;
    step();
    step();

    // Expiry with a sole requester
    req = 4'b0001;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk("expiry_gnt", int'(gnt), (s % 5 != 0) ? 1 : 0);
      chk("expiry_exp", int'(expired), (s % 5 == 0) ? 1 : 0);
    end
    req = 4'b0000;
    reset = 1'b1;
    #5 reset = 1'b0;
    step();

    // Full rotation with everyone requesting
    req = 4'b1111;
    exp_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        step();
        if (c < 4) begin
          chk("rot_gnt",   int'(gnt), 1 << (r % N));
          chk("rot_owner", int'(owner), r % N);
          chk("rot_noexp", int'(expired), 0);
        end else begin
          chk("rot_gap_gnt", int'(gnt), 0);
          chk("rot_gap_exp", int'(expired), 1);
          if (r < 4) exp_cnt++;
        end
      end
    end
    chk("rot_expired_count", exp_cnt, 4);

    // Release coinciding with hold limit
    req = 4'b0010;
    for (int s = 1; s <= 4; s++) begin
      step();
      chk("relmax_gnt", int'(gnt), 2);
    end
    req = 4'b0000;
    step();
    chk("relmax_gnt_off", int'(gnt), 0);
    chk("relmax_noexp",   int'(expired), 0);

    // Async reset in the middle of a grant
    req = 4'b0010;
    step();
    chk("arst_pre_gnt", int'(gnt), 2);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_gnt",   int'(gnt), 0);
    chk("arst_busy",  int'(busy), 0);
    chk("arst_owner", int'(owner), 0);
    chk("arst_exp",   int'(expired), 0);
    #3 req = 4'b1111;
    step();
    reset = 1'b0;
    step();
    chk("arst_regrant_gnt",   int'(gnt), 1);
    chk("arst_regrant_owner", int'(owner), 0);
    req = 4'b0000;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
